// File: rtl/ram_bus_term.sv
// CPU bus terminator for the DRAM window: decodes RAM hits, gates DRAM starts and passes acknowledges to STERM.
// Optional watchdog/bus-error path enabled by defining RAM_BUS_TERM_BERR_EN.
module ram_bus_term #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       sysClk,
  input  logic       sysRESETn,
  input  logic [3:0] cpuAddr,
  input  logic [2:0] cpuFC,
  input  logic       cpuASn,
  input  logic       ramACKn,
  output logic       ramCEn,
  output logic       cpuSTERMn,
  output logic       cpuBERRn
);

  localparam int unsigned CNT_W = 8;

  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("ram_bus_term: TIMEOUT_CYCLES must be within 4..255");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_DONE   = 3'd2,
    ST_SKIP   = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   ram_ce_n_q, ram_ce_n_d;
  logic   ram_hit_c;
  logic   timeout_c;
  logic   unused_addr;

  // Only A31..A30 select the DRAM window; CPU space (FC=7) never hits.
  assign ram_hit_c   = (cpuAddr[3:2] == 2'b00) && (cpuFC != 3'b111);
  assign unused_addr = ^cpuAddr[1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!cpuASn) state_d = ram_hit_c ? ST_ACTIVE : ST_SKIP;
      end
      ST_ACTIVE: begin
        // Acknowledge wins over a coincident timeout.
        if (!ramACKn)       state_d = ST_DONE;
        else if (timeout_c) state_d = ST_ERROR;
        else if (cpuASn)    state_d = ST_IDLE;
      end
      ST_DONE, ST_SKIP, ST_ERROR: begin
        if (cpuASn) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_ce_n_d = (state_d != ST_ACTIVE);
  end

  always_ff @(posedge sysClk or negedge sysRESETn) begin
    if (!sysRESETn) begin
      state_q    <= ST_IDLE;
      ram_ce_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ram_ce_n_q <= ram_ce_n_d;
    end
  end

  assign ramCEn    = ram_ce_n_q;
  // Every burst acknowledge is forwarded for as long as the cycle is owned by DRAM.
  assign cpuSTERMn = ((state_q == ST_ACTIVE) || (state_q == ST_DONE)) ? ramACKn : 1'b1;

`ifdef RAM_BUS_TERM_BERR_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             berr_n_q, berr_n_d;

  // Counter sits at zero outside ACTIVE, so it is clear on every entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_ACTIVE) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
    berr_n_d = (state_d != ST_ERROR);
  end

  assign timeout_c = (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge sysClk or negedge sysRESETn) begin
    if (!sysRESETn) begin
      cnt_q    <= '0;
      berr_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      berr_n_q <= berr_n_d;
    end
  end

  assign cpuBERRn = berr_n_q;
`else
  assign timeout_c = 1'b0;
  assign cpuBERRn  = 1'b1;
`endif

endmodule

// File: tb/tb_ram_bus_term.sv
// Self-checking bench for ram_bus_term: fixed vector table, hand-written corner sequences, randomized run vs. a cycle model.
module tb_ram_bus_term;

  localparam int TMO = 8;

  logic       sysClk;
  logic       sysRESETn;
  logic [3:0] cpuAddr;
  logic [2:0] cpuFC;
  logic       cpuASn;
  logic       ramACKn;
  logic       ramCEn;
  logic       cpuSTERMn;
  logic       cpuBERRn;

  int n_checks = 0;
  int n_errors = 0;

  ram_bus_term #(.TIMEOUT_CYCLES(TMO)) dut (
    .sysClk    (sysClk),
    .sysRESETn (sysRESETn),
    .cpuAddr   (cpuAddr),
    .cpuFC     (cpuFC),
    .cpuASn    (cpuASn),
    .ramACKn   (ramACKn),
    .ramCEn    (ramCEn),
    .cpuSTERMn (cpuSTERMn),
    .cpuBERRn  (cpuBERRn)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

`ifdef RAM_BUS_TERM_BERR_EN
  localparam bit BERR_ON = 1'b1;
`else
  localparam bit BERR_ON = 1'b0;
`endif

  // Behavioural model: which phase the CPU cycle is in and how many edges it has spent waiting on DRAM.
  typedef enum int { P_IDLE, P_WAIT, P_ACKED, P_FOREIGN, P_FAULT } phase_e;
  phase_e m_phase;
  int     m_wait_edges;

  function automatic bit is_ram(input logic [3:0] a, input logic [2:0] f);
    return (int'(a) < 4) && (int'(f) != 7);
  endfunction

  task automatic model_reset();
    m_phase      = P_IDLE;
    m_wait_edges = 0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [2:0] f, input logic asn, input logic ackn);
    case (m_phase)
      P_IDLE: if (!asn) begin
        m_phase      = is_ram(a, f) ? P_WAIT : P_FOREIGN;
        m_wait_edges = 0;
      end
      P_WAIT: begin
        m_wait_edges++;
        if (!ackn)                               m_phase = P_ACKED;
        else if (BERR_ON && m_wait_edges >= TMO) m_phase = P_FAULT;
        else if (asn)                            m_phase = P_IDLE;
      end
      default: if (asn) m_phase = P_IDLE;
    endcase
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, check combinational STERM, clock, check registered outputs.
  task automatic cyc(input logic [3:0] a, input logic [2:0] f, input logic asn, input logic ackn,
                     output logic o_sterm, output logic o_ce, output logic o_berr);
    cpuAddr = a; cpuFC = f; cpuASn = asn; ramACKn = ackn;
    #1;
    o_sterm = cpuSTERMn;
    chk("model_sterm", cpuSTERMn,
        (m_phase == P_WAIT || m_phase == P_ACKED) ? ackn : 1'b1);
    @(posedge sysClk);
    model_edge(a, f, asn, ackn);
    #1;
    o_ce   = ramCEn;
    o_berr = cpuBERRn;
    chk("model_ce_n", ramCEn, m_phase != P_WAIT);
    chk("model_berr_n", cpuBERRn, m_phase != P_FAULT);
  endtask

  task automatic pulse_reset();
    sysRESETn = 1'b0;
    #2;
    chk("rst_ce_n", ramCEn, 1'b1);
    chk("rst_sterm_n", cpuSTERMn, 1'b1);
    chk("rst_berr_n", cpuBERRn, 1'b1);
    model_reset();
    #2;
    sysRESETn = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0] addr;
    logic [2:0] fc;
    logic       asn;
    logic       ackn;
    logic       exp_sterm_n;
    logic       exp_ce_n;
    logic       exp_berr_n;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic s, c, b;

    //            addr   fc    asn   ack   sterm ce    berr
    vecs[0]  = '{4'h0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{4'h0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{4'h0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{4'h0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{4'h0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{4'h0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{4'h0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{4'h0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{4'h8, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{4'h8, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{4'h8, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{4'h0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{4'h0, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{4'h0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{4'h3, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{4'h3, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[16] = '{4'h4, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{4'h4, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    sysRESETn = 1'b0;
    cpuAddr = 4'h0; cpuFC = 3'd5; cpuASn = 1'b1; ramACKn = 1'b0;
    model_reset();
    repeat (2) @(posedge sysClk);
    #1;
    chk("reset_ce_n", ramCEn, 1'b1);
    chk("reset_sterm_n", cpuSTERMn, 1'b1);
    chk("reset_berr_n", cpuBERRn, 1'b1);
    @(negedge sysClk);
    sysRESETn = 1'b1;
    #1;

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].addr, vecs[i].fc, vecs[i].asn, vecs[i].ackn, s, c, b);
      chk($sformatf("vec%0d_sterm", i), s, vecs[i].exp_sterm_n);
      chk($sformatf("vec%0d_ce_n", i), c, vecs[i].exp_ce_n);
      chk($sformatf("vec%0d_berr_n", i), b, vecs[i].exp_berr_n);
    end

    // Reset asserted in the middle of an ACTIVE cycle with an acknowledge pending.
    cyc(4'h1, 3'd6, 1'b0, 1'b1, s, c, b);
    chk("pre_rst_ce_n", c, 1'b0);
    ramACKn = 1'b0;
    #1;
    chk("pre_rst_sterm", cpuSTERMn, 1'b0);
    pulse_reset();
    cyc(4'h1, 3'd6, 1'b0, 1'b1, s, c, b);
    chk("post_rst_ce_n", c, 1'b0);
    cyc(4'h1, 3'd6, 1'b1, 1'b1, s, c, b);
    chk("post_rst_abort_ce_n", c, 1'b1);

`ifdef RAM_BUS_TERM_BERR_EN
    // No acknowledge: bus error from the TMO-th ACTIVE edge until AS is released.
    cyc(4'h0, 3'd1, 1'b0, 1'b1, s, c, b);
    for (int i = 1; i < TMO; i++) cyc(4'h0, 3'd1, 1'b0, 1'b1, s, c, b);
    chk("tmo_pre_ce_n", c, 1'b0);
    chk("tmo_pre_berr_n", b, 1'b1);
    cyc(4'h0, 3'd1, 1'b0, 1'b1, s, c, b);
    chk("tmo_berr_n", b, 1'b0);
    chk("tmo_ce_n", c, 1'b1);
    cyc(4'h0, 3'd1, 1'b0, 1'b0, s, c, b);
    chk("tmo_hold_berr_n", b, 1'b0);
    chk("tmo_ack_ignored_sterm", s, 1'b1);
    cyc(4'h0, 3'd1, 1'b1, 1'b1, s, c, b);
    chk("tmo_release_berr_n", b, 1'b1);
    // Acknowledge on the same edge as the timeout wins.
    cyc(4'h0, 3'd1, 1'b0, 1'b1, s, c, b);
    for (int i = 1; i < TMO; i++) cyc(4'h0, 3'd1, 1'b0, 1'b1, s, c, b);
    cyc(4'h0, 3'd1, 1'b0, 1'b0, s, c, b);
    chk("tmo_race_sterm", s, 1'b0);
    chk("tmo_race_berr_n", b, 1'b1);
    chk("tmo_race_ce_n", c, 1'b1);
    cyc(4'h0, 3'd1, 1'b1, 1'b1, s, c, b);
`else
    // Without the watchdog the access waits as long as the CPU holds AS.
    cyc(4'h0, 3'd1, 1'b0, 1'b1, s, c, b);
    for (int i = 0; i < 300; i++) cyc(4'h0, 3'd1, 1'b0, 1'b1, s, c, b);
    chk("nowd_ce_n", c, 1'b0);
    chk("nowd_berr_n", b, 1'b1);
    cyc(4'h0, 3'd1, 1'b1, 1'b1, s, c, b);
    chk("nowd_release_ce_n", c, 1'b1);
`endif

    // Randomized traffic against the model, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ra;
      logic [2:0] rf;
      logic       rasn, rack;
      ra   = 4'($urandom_range(0, 15));
      rf   = ($urandom_range(0, 5) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      if (ra > 4'h7 && $urandom_range(0, 1) == 0) ra = ra & 4'h3;
      rasn = ($urandom_range(0, 3) == 0);
      rack = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      cyc(ra, rf, rasn, rack, s, c, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_bus_term.md
RAM_BUS_TERM -- requirements
Module: ram_bus_term

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning sysClk cycles in ACTIVE without acknowledge before bus error; legal range 4..255.
REQ-002 SHALL have port sysClk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port sysRESETn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cpuAddr, input, 4, CPU address bits A31..A28.
REQ-005 SHALL have port cpuFC, input, 3, CPU function code.
REQ-006 SHALL have port cpuASn, input, 1, CPU address strobe, active low.
REQ-007 SHALL have port ramACKn, input, 1, per-longword acknowledge from DRAM controller, active low.
REQ-008 SHALL have port ramCEn, output, 1, registered RAM chip enable to DRAM controller, active low.
REQ-009 SHALL have port cpuSTERMn, output, 1, CPU synchronous termination, active low.
REQ-010 SHALL have port cpuBERRn, output, 1, registered CPU bus error, active low.

Function
REQ-011 RAM hit SHALL be: cpuAddr[3:2]==2'b00 and cpuFC!=3'b111.
REQ-012 State machine SHALL have states IDLE, ACTIVE, DONE, SKIP, ERROR.
REQ-013 IDLE: cpuASn low and RAM hit -> ACTIVE; cpuASn low and no hit -> SKIP; else stay.
REQ-014 ACTIVE: ramACKn low -> DONE; else timeout reached -> ERROR; else cpuASn high -> IDLE (aborted cycle); else stay. ramACKn low SHALL take priority over a simultaneous timeout.
REQ-015 DONE, SKIP, ERROR: cpuASn high -> IDLE; else stay.
REQ-016 ramCEn SHALL be low exactly while state is ACTIVE (registered; low from the edge entering ACTIVE, high from the edge leaving it), so the DRAM controller starts one access per CPU cycle.
REQ-017 cpuSTERMn SHALL equal ramACKn while state is ACTIVE or DONE, and be high otherwise (combinational), passing every burst acknowledge through.
REQ-018 cpuBERRn SHALL be low exactly while state is ERROR.
REQ-019 Timeout counter SHALL be 8 bits; it clears on entry to ACTIVE, increments each ACTIVE cycle, saturates, and signals timeout when its value equals TIMEOUT_CYCLES-1.
REQ-020 Back-to-back cycles SHALL require cpuASn sampled high at least one edge; no new ACTIVE begins from DONE/SKIP/ERROR without passing IDLE.
REQ-021 ramACKn low outside ACTIVE/DONE SHALL be ignored.

Reset
REQ-022 sysRESETn low SHALL immediately force state IDLE, counter 0, ramCEn=1, cpuBERRn=1, cpuSTERMn=1, including mid-cycle.
REQ-023 After reset release, the first access SHALL be decoded normally at the next rising edge.

Configuration
REQ-024 Macro RAM_BUS_TERM_BERR_EN SHALL control the timeout watchdog.
REQ-025 With RAM_BUS_TERM_BERR_EN defined: counter, ERROR state and cpuBERRn function per REQ-014/018/019.
REQ-026 Without it: no counter logic; ACTIVE waits indefinitely for ramACKn or cpuASn high; cpuBERRn tied high; ERROR unreachable.

Verification
REQ-027 Reset, then read at cpuAddr=4'h0, FC=5, ACK low on 3rd ACTIVE cycle -> ramCEn low 3 cycles, cpuSTERMn low that cycle, ramCEn high after, BERRn stays 1.
REQ-028 Burst: ACK low 4 separated pulses while ASn held low -> four cpuSTERMn pulses, ramCEn low only until first ACK.
REQ-029 Access at cpuAddr=4'h8 or FC=7 -> ramCEn and cpuSTERMn stay high, state SKIP until ASn high.
REQ-030 BERR_EN defined, TIMEOUT_CYCLES=8, no ACK -> cpuBERRn low from 8th ACTIVE edge until ASn high, ramCEn high; ACK arriving on 8th edge -> DONE, no BERR.
REQ-031 sysRESETn pulsed low during ACTIVE -> ramCEn, cpuSTERMn, cpuBERRn high without clock edge; ASn still low after release with RAM hit -> new ACTIVE.
REQ-032 BERR_EN undefined, no ACK for 300 cycles -> ramCEn remains low, cpuBERRn stays high; ASn high -> IDLE.
